// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the IFU and LSU requesters, the memory arbiter
// and the shared bus port. slave = arbiter side, master = requesters plus bus.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned MASK_W = DATA_W / 8;

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_rsp_valid;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              lsu_rsp_valid;
  logic [DATA_W-1:0] lsu_rdata;

  logic              bus_req_valid;
  logic              bus_req_ready;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_wen;
  logic [DATA_W-1:0] bus_wdata;
  logic [MASK_W-1:0] bus_wmask;
  logic              bus_rsp_valid;
  logic [DATA_W-1:0] bus_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_rsp_valid, lsu_rdata,
    output bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wmask,
    input  bus_req_ready, bus_rsp_valid, bus_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rdata,
    input  bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wmask,
    output bus_req_ready, bus_rsp_valid, bus_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between fetch (IFU) and load/store (LSU), one
// transaction outstanding; LSU has priority, capped by a streak counter.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LSU_STREAK = 4
) (
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus_if
);
  localparam int unsigned MASK_W     = DATA_W / 8;
  localparam logic [3:0]  STREAK_MAX = 4'(LSU_STREAK);

  typedef enum logic [1:0] {IDLE, BUS_REQ, WAIT_RSP} state_e;

  state_e            state_q;
  logic              owner_lsu_q;
  logic [3:0]        streak_q, streak_d;
  logic              bus_req_valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;

  logic grant_ifu, grant_lsu, rsp_fire;

  // LSU wins ties until it has been granted STREAK_MAX times in a row over a waiting IFU.
  always_comb begin
    grant_lsu = 1'b0;
    grant_ifu = 1'b0;
    if (state_q == IDLE) begin
      if (bus_if.lsu_req_valid && (!bus_if.ifu_req_valid || streak_q != STREAK_MAX))
        grant_lsu = 1'b1;
      else if (bus_if.ifu_req_valid)
        grant_ifu = 1'b1;
    end
    streak_d = streak_q;
    if (grant_lsu && bus_if.ifu_req_valid)
      streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
    else if (grant_lsu || grant_ifu)
      streak_d = '0;
  end

  assign rsp_fire = (state_q == WAIT_RSP) && bus_if.bus_rsp_valid;

  assign bus_if.ifu_req_ready = grant_ifu;
  assign bus_if.lsu_req_ready = grant_lsu;
  assign bus_if.ifu_rsp_valid = rsp_fire && !owner_lsu_q;
  assign bus_if.lsu_rsp_valid = rsp_fire && owner_lsu_q;
  assign bus_if.ifu_rdata     = bus_if.ifu_rsp_valid ? bus_if.bus_rdata : '0;
  assign bus_if.lsu_rdata     = bus_if.lsu_rsp_valid ? bus_if.bus_rdata : '0;

  assign bus_if.bus_req_valid = bus_req_valid_q;
  assign bus_if.bus_addr      = addr_q;
  assign bus_if.bus_wen       = wen_q;
  assign bus_if.bus_wdata     = wdata_q;
  assign bus_if.bus_wmask     = wmask_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      owner_lsu_q     <= 1'b0;
      streak_q        <= '0;
      bus_req_valid_q <= 1'b0;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      wmask_q         <= '0;
    end else begin
      streak_q <= streak_d;
      case (state_q)
        IDLE: begin
          if (grant_lsu || grant_ifu) begin
            state_q         <= BUS_REQ;
            bus_req_valid_q <= 1'b1;
            owner_lsu_q     <= grant_lsu;
            addr_q          <= grant_lsu ? bus_if.lsu_addr  : bus_if.ifu_addr;
            wen_q           <= grant_lsu && bus_if.lsu_wen;
            wdata_q         <= grant_lsu ? bus_if.lsu_wdata : '0;
            wmask_q         <= grant_lsu ? bus_if.lsu_wmask : '0;
          end
        end
        BUS_REQ: begin
          if (bus_if.bus_req_ready) begin
            state_q         <= WAIT_RSP;
            bus_req_valid_q <= 1'b0;
          end
        end
        WAIT_RSP: begin
          if (bus_if.bus_rsp_valid) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: stimulus queues expected bus
// requests and responses, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam logic [31:0] RSP_KEY = 32'h8000_0013;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  typedef struct packed {
    logic        is_lsu;
    logic        chk;
    logic [31:0] rdata;
  } rsp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LSU_STREAK(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus_if (bif)
  );

  always #5 clock = ~clock;

  req_t        exp_req[$];
  rsp_t        exp_rsp[$];
  logic [31:0] ifu_q[$];
  req_t        lsu_q[$];
  int          grant_cyc[$];
  int          vectors = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lsu_grants = 0;
  int          last_rsp_cyc = 0;
  logic        bus_en = 1'b0;
  logic        man_rsp = 1'b0;
  logic [31:0] man_rdata = '0;
  int          bus_stall = 0;
  int          rsp_gap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_txn(input logic is_lsu, input logic [31:0] addr, input logic wen,
                            input logic [31:0] wdata, input logic [3:0] wmask,
                            input logic chk, input logic [31:0] rdata);
    exp_req.push_back('{addr, wen, wdata, wmask});
    exp_rsp.push_back('{is_lsu, chk, rdata});
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while ((exp_rsp.size() + exp_req.size() + ifu_q.size() + lsu_q.size()) != 0 && n < max_cyc) begin
      @(posedge clock);
      n++;
    end
    check({name, "_drained"}, exp_rsp.size() + exp_req.size() + ifu_q.size() + lsu_q.size(), 0);
    repeat (2) @(negedge clock);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // IFU requester: holds valid and address until accepted.
  initial begin
    logic acc;
    bif.ifu_req_valid = 1'b0;
    bif.ifu_addr      = '0;
    forever begin
      @(negedge clock);
      acc = bif.ifu_req_ready;
      @(posedge clock);
      #1;
      if (acc && ifu_q.size() > 0) void'(ifu_q.pop_front());
      if (ifu_q.size() > 0) begin
        bif.ifu_req_valid = 1'b1;
        bif.ifu_addr      = ifu_q[0];
      end else begin
        bif.ifu_req_valid = 1'b0;
        bif.ifu_addr      = '0;
      end
    end
  end

  // LSU requester.
  initial begin
    logic acc;
    bif.lsu_req_valid = 1'b0;
    bif.lsu_addr      = '0;
    bif.lsu_wen       = 1'b0;
    bif.lsu_wdata     = '0;
    bif.lsu_wmask     = '0;
    forever begin
      @(negedge clock);
      acc = bif.lsu_req_ready;
      @(posedge clock);
      #1;
      if (acc && lsu_q.size() > 0) void'(lsu_q.pop_front());
      if (lsu_q.size() > 0) begin
        bif.lsu_req_valid = 1'b1;
        bif.lsu_addr      = lsu_q[0].addr;
        bif.lsu_wen       = lsu_q[0].wen;
        bif.lsu_wdata     = lsu_q[0].wdata;
        bif.lsu_wmask     = lsu_q[0].wmask;
      end else begin
        bif.lsu_req_valid = 1'b0;
        bif.lsu_addr      = '0;
        bif.lsu_wen       = 1'b0;
        bif.lsu_wdata     = '0;
        bif.lsu_wmask     = '0;
      end
    end
  end

  // Bus slave model: stalls bus_stall cycles, responds rsp_gap cycles after acceptance.
  initial begin
    int          stall;
    int          gap;
    logic        pending;
    logic [31:0] cap;
    stall = 0; gap = 0; pending = 1'b0; cap = '0;
    bif.bus_req_ready = 1'b0;
    bif.bus_rsp_valid = 1'b0;
    bif.bus_rdata     = '0;
    forever begin
      @(posedge clock);
      #1;
      if (!bus_en) begin
        bif.bus_req_ready = 1'b0;
        bif.bus_rsp_valid = man_rsp;
        bif.bus_rdata     = man_rdata;
        stall = 0;
        pending = 1'b0;
      end else begin
        if (bif.bus_rsp_valid) begin
          bif.bus_rsp_valid = 1'b0;
          bif.bus_rdata     = '0;
        end
        if (bif.bus_req_ready) begin
          bif.bus_req_ready = 1'b0;
          if (rsp_gap == 0) begin
            bif.bus_rsp_valid = 1'b1;
            bif.bus_rdata     = cap ^ RSP_KEY;
          end else begin
            pending = 1'b1;
            gap     = rsp_gap - 1;
          end
        end else if (pending) begin
          if (gap == 0) begin
            bif.bus_rsp_valid = 1'b1;
            bif.bus_rdata     = cap ^ RSP_KEY;
            pending = 1'b0;
          end else begin
            gap--;
          end
        end else if (bif.bus_req_valid) begin
          if (stall >= bus_stall) begin
            bif.bus_req_ready = 1'b1;
            stall = 0;
            cap   = bif.bus_addr;
          end else begin
            stall++;
          end
        end
      end
    end
  end

  // Monitor: grant bookkeeping, bus-request field checks, response scoreboard.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        check("dual_ready", {31'd0, bif.ifu_req_ready & bif.lsu_req_ready}, 0);
        if (bif.ifu_req_ready || bif.lsu_req_ready) grant_cyc.push_back(cyc);
        if (bif.lsu_req_ready) lsu_grants++;
        if (bif.bus_req_valid) begin
          if (exp_req.size() == 0) begin
            check("unexpected_bus_req", {31'd0, bif.bus_req_valid}, 0);
          end else begin
            check("bus_addr",  bif.bus_addr,  exp_req[0].addr);
            check("bus_wen",   {31'd0, bif.bus_wen}, {31'd0, exp_req[0].wen});
            check("bus_wdata", bif.bus_wdata, exp_req[0].wdata);
            check("bus_wmask", {28'd0, bif.bus_wmask}, {28'd0, exp_req[0].wmask});
            if (bif.bus_req_ready) void'(exp_req.pop_front());
          end
        end
        if (bif.ifu_rsp_valid || bif.lsu_rsp_valid) begin
          last_rsp_cyc = cyc;
          if (exp_rsp.size() == 0) begin
            check("unexpected_rsp", {30'd0, bif.ifu_rsp_valid, bif.lsu_rsp_valid}, 0);
          end else begin
            e = exp_rsp.pop_front();
            check("rsp_owner", {30'd0, bif.ifu_rsp_valid, bif.lsu_rsp_valid},
                  e.is_lsu ? 32'd1 : 32'd2);
            if (e.chk) check("rsp_rdata", e.is_lsu ? bif.lsu_rdata : bif.ifu_rdata, e.rdata);
            check("rsp_other_rdata", e.is_lsu ? bif.ifu_rdata : bif.lsu_rdata, 0);
          end
        end else begin
          check("rdata_idle", bif.ifu_rdata | bif.lsu_rdata, 0);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ifu_ready"}, {31'd0, bif.ifu_req_ready}, 0);
    check({tag, "_lsu_ready"}, {31'd0, bif.lsu_req_ready}, 0);
    check({tag, "_ifu_rspv"},  {31'd0, bif.ifu_rsp_valid}, 0);
    check({tag, "_lsu_rspv"},  {31'd0, bif.lsu_rsp_valid}, 0);
    check({tag, "_bus_reqv"},  {31'd0, bif.bus_req_valid}, 0);
    check({tag, "_bus_addr"},  bif.bus_addr, 0);
    check({tag, "_bus_wen"},   {31'd0, bif.bus_wen}, 0);
    check({tag, "_bus_wdata"}, bif.bus_wdata, 0);
    check({tag, "_bus_wmask"}, {28'd0, bif.bus_wmask}, 0);
    check({tag, "_ifu_rdata"}, bif.ifu_rdata, 0);
    check({tag, "_lsu_rdata"}, bif.lsu_rdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    n;
    int    base;
    int    li;
    int    ii;
    string order;

    // Reset state
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;

    // 1. Reset while in BUS_REQ, then stale bus response in IDLE
    bus_en = 1'b0;
    expect_txn(1'b0, 32'h0000_4000, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
    ifu_q.push_back(32'h0000_4000);
    n = 0;
    while (!bif.bus_req_valid && n < 20) begin @(negedge clock); n++; end
    check("busreq_before_reset", {31'd0, bif.bus_req_valid}, 1);
    check("busaddr_before_reset", bif.bus_addr, 32'h0000_4000);
    @(posedge clock);
    #3 reset = 1'b1;
    ifu_q.delete();
    exp_req.delete();
    exp_rsp.delete();
    #1 check_all_zero("midop_reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    man_rsp = 1'b1;
    man_rdata = 32'hFFFF_FFFF;
    repeat (3) begin
      @(negedge clock);
      check("stale_rsp_ifu", {31'd0, bif.ifu_rsp_valid}, 0);
      check("stale_rsp_lsu", {31'd0, bif.lsu_rsp_valid}, 0);
    end
    man_rsp = 1'b0;
    man_rdata = '0;
    repeat (2) @(negedge clock);
    bus_en = 1'b1;

    // 2. Single fetch; ready at T+1, response at T+3
    bus_stall = 0;
    rsp_gap   = 1;
    base = grant_cyc.size();
    expect_txn(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0000_0013);
    ifu_q.push_back(32'h8000_0000);
    wait_drain("fetch", 50);
    check("fetch_grants", grant_cyc.size() - base, 1);
    if (grant_cyc.size() > base) check("fetch_latency", last_rsp_cyc - grant_cyc[base], 3);

    // 3. Store held stable through three stall cycles
    bus_stall = 3;
    expect_txn(1'b1, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 4'b0011, 1'b0, 32'h0);
    lsu_q.push_back('{32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 4'b0011});
    wait_drain("store", 50);

    // 4 + 6. Both requesters saturated: L,L,L,L,I pattern at a 3-cycle cadence
    bus_stall = 0;
    rsp_gap   = 0;
    order = "LLLLILLLLILLLLI";
    li = 0;
    ii = 0;
    for (int k = 0; k < order.len(); k++) begin
      if (order[k] == "L") begin
        expect_txn(1'b1, 32'h0000_2000 + 32'(4 * li), 1'b0, 32'h0, 4'hF, 1'b1,
                   (32'h0000_2000 + 32'(4 * li)) ^ RSP_KEY);
        li++;
      end else begin
        expect_txn(1'b0, 32'h0000_1000 + 32'(4 * ii), 1'b0, 32'h0, 4'h0, 1'b1,
                   (32'h0000_1000 + 32'(4 * ii)) ^ RSP_KEY);
        ii++;
      end
    end
    base = grant_cyc.size();
    @(negedge clock);
    for (int k = 0; k < 12; k++) lsu_q.push_back('{32'h0000_2000 + 32'(4 * k), 1'b0, 32'h0, 4'hF});
    for (int k = 0; k < 3; k++)  ifu_q.push_back(32'h0000_1000 + 32'(4 * k));
    wait_drain("fair", 200);
    check("fair_grants", grant_cyc.size() - base, 15);
    for (int k = base + 1; k < grant_cyc.size(); k++)
      check("b2b_cadence", grant_cyc[k] - grant_cyc[k-1], 3);

    // 5. LSU alone for 10 grants, then IFU joins and must win within 4 more
    for (int k = 0; k < 20; k++) begin
      if (k == 14) expect_txn(1'b0, 32'h0000_3000, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0000_3000 ^ RSP_KEY);
      expect_txn(1'b1, 32'h0000_5000 + 32'(4 * k), 1'b0, 32'h0, 4'hF, 1'b1,
                 (32'h0000_5000 + 32'(4 * k)) ^ RSP_KEY);
    end
    base = lsu_grants;
    @(negedge clock);
    for (int k = 0; k < 20; k++) lsu_q.push_back('{32'h0000_5000 + 32'(4 * k), 1'b0, 32'h0, 4'hF});
    n = 0;
    while (lsu_grants < base + 10 && n < 200) begin @(posedge clock); n++; end
    check("lsu_alone_grants", lsu_grants - base, 10);
    ifu_q.push_back(32'h0000_3000);
    wait_drain("join", 300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
